// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter and sequencer for a single-port synchronous memory.
// Ports: clk/rst_n (sync active-low); APB slave (psel, penable, pwrite, paddr, pwdata,
//   prdata, pready, pslverr); B req/ack port (b_req, b_we, b_addr, b_wdata, b_ack,
//   b_rdata, b_err); memory side (mem_ce, mem_rden, mem_wren, mem_addr, mem_wr_data,
//   mem_rd_data).
module mem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter int ARB_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [7:0]        pwdata,
    output logic [7:0]        prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_wdata,
    output logic              b_ack,
    output logic [7:0]        b_rdata,
    output logic              b_err,
    output logic              mem_ce,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wr_data,
    input  logic [7:0]        mem_rd_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    state_t state, state_n;
    logic grant, grant_n;
    logic last_grant, last_grant_n;
    logic err, err_n;
    logic rd, rd_n;
    logic ce_n, rden_n, wren_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0] wdata_n;
    logic pready_n, pslverr_n;
    logic b_ack_n, b_err_n;

    logic a_pend, b_pend, b_wins;
    logic req_we, in_range;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0] req_wdata;
    logic rd_ok;

    assign a_pend = psel & penable & (state == IDLE);
    assign b_pend = b_req & (state == IDLE);

    // B only beats A in round-robin mode when A was served last.
    always_comb begin
        b_wins = 1'b0;
        if (ARB_MODE == 1) begin
            b_wins = b_pend & ~a_pend;
        end else begin
            b_wins = b_pend & (~a_pend | (last_grant == GRANT_A));
        end
    end

    assign req_we    = b_wins ? b_we    : pwrite;
    assign req_addr  = b_wins ? b_addr  : paddr;
    assign req_wdata = b_wins ? b_wdata : pwdata;
    assign in_range  = (32'(req_addr) < DEPTH);

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        last_grant_n = last_grant;
        err_n        = err;
        rd_n         = rd;
        ce_n         = 1'b0;
        rden_n       = 1'b0;
        wren_n       = 1'b0;
        addr_n       = mem_addr;
        wdata_n      = mem_wr_data;
        pready_n     = 1'b0;
        pslverr_n    = 1'b0;
        b_ack_n      = 1'b0;
        b_err_n      = 1'b0;
        unique case (state)
            IDLE: begin
                if (a_pend | b_pend) begin
                    grant_n      = b_wins;
                    last_grant_n = b_wins;
                    err_n        = ~in_range;
                    rd_n         = ~req_we;
                    state_n      = ACCESS;
                    // Out-of-range requests never touch the memory.
                    if (in_range) begin
                        addr_n  = req_addr;
                        wdata_n = req_wdata;
                        ce_n    = 1'b1;
                        rden_n  = ~req_we;
                        wren_n  = req_we;
                    end
                end
            end
            ACCESS: begin
                state_n   = RESP;
                pready_n  = (grant == GRANT_A);
                pslverr_n = (grant == GRANT_A) & err;
                b_ack_n   = (grant == GRANT_B);
                b_err_n   = (grant == GRANT_B) & err;
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= GRANT_A;
            last_grant  <= GRANT_B;
            err         <= 1'b0;
            rd          <= 1'b0;
            mem_ce      <= 1'b0;
            mem_rden    <= 1'b0;
            mem_wren    <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            pready      <= 1'b0;
            pslverr     <= 1'b0;
            b_ack       <= 1'b0;
            b_err       <= 1'b0;
        end else begin
            state       <= state_n;
            grant       <= grant_n;
            last_grant  <= last_grant_n;
            err         <= err_n;
            rd          <= rd_n;
            mem_ce      <= ce_n;
            mem_rden    <= rden_n;
            mem_wren    <= wren_n;
            mem_addr    <= addr_n;
            mem_wr_data <= wdata_n;
            pready      <= pready_n;
            pslverr     <= pslverr_n;
            b_ack       <= b_ack_n;
            b_err       <= b_err_n;
        end
    end

    // Memory read data lands during RESP; pass it through only for a good read.
    assign rd_ok   = (state == RESP) & ~err & rd;
    assign prdata  = (rd_ok && grant == GRANT_A) ? mem_rd_data : 8'h00;
    assign b_rdata = (rd_ok && grant == GRANT_B) ? mem_rd_data : 8'h00;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the 8-bit single-port synchronous memory (ce/wren/rden/addr/wr_data/rd_data).
- Requester A is an APB slave port (CPU side). Requester B is a simple req/ack port for the I2C engine.
- Serialises accesses, drives memory controls with the correct timing, and returns read data plus completion to the winning requester.

Parameters:
- ADDR_W, 8, address width of both ports and the memory.
- DEPTH, 256, number of implemented memory locations. Any address >= DEPTH is an error.
- ARB_MODE, 0, 0 = round-robin between A and B; 1 = fixed priority with A highest.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  APB direction, 1 = write.
- paddr  in  ADDR_W  APB address.
- pwdata  in  8  APB write data.
- prdata  out  8  APB read data.
- pready  out  1  APB transfer complete.
- pslverr  out  1  APB error, address out of range.
- b_req  in  1  B request, level, held until b_ack.
- b_we  in  1  B direction, 1 = write.
- b_addr  in  ADDR_W  B address.
- b_wdata  in  8  B write data.
- b_ack  out  1  B completion, one-cycle pulse.
- b_rdata  out  8  B read data, valid with b_ack.
- b_err  out  1  B error, valid with b_ack.
- mem_ce  out  1  memory chip enable.
- mem_rden  out  1  memory read enable.
- mem_wren  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wr_data  out  8  memory write data.
- mem_rd_data  in  8  memory read data, registered inside the memory.

Behaviour:
- One clock (clk). Reset is synchronous, active-low (rst_n).
- Reset values: state = IDLE; all of mem_ce, mem_rden, mem_wren, pready, pslverr, b_ack, b_err = 0; mem_addr, mem_wr_data, prdata, b_rdata = 0; last_grant = B.
- Memory model contract:
  - Controls are sampled at a rising edge.
  - Read data is valid on mem_rd_data from the following cycle.
  - A write takes effect at the sampling edge.
- Request definitions:
  - A pending = psel & penable & (state == IDLE).
  - B pending = b_req & (state == IDLE).
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - No request pending: stay in IDLE.
  - Otherwise pick a winner:
    - ARB_MODE=1: A wins any tie.
    - ARB_MODE=0: the requester not equal to last_grant wins a tie.
    - A lone requester always wins.
  - Register grant and update last_grant.
  - Address in range: register mem_addr and mem_wr_data; set mem_ce=1; set mem_rden = !write, mem_wren = write; go to ACCESS.
  - Address out of range: memory controls stay 0; go to ACCESS with err flag set.
- ACCESS:
  - Memory samples the controls at the end of this cycle.
  - Clear mem_ce, mem_rden and mem_wren (registered) on that same edge; go to RESP.
- RESP (exactly one cycle), then return to IDLE:
  - Grant A: pready=1 and pslverr=err; prdata = mem_rd_data for an in-range read, else 0.
  - Grant B: b_ack=1 and b_err=err; b_rdata = mem_rd_data for an in-range read, else 0.
  - pready, pslverr, b_ack and b_err are registered, asserted only in RESP.
  - prdata and b_rdata are combinational from mem_rd_data, qualified by RESP and grant.
- Latency:
  - APB access phase seen in IDLE at cycle T gives pready=1 in cycle T+2 (two wait states).
  - B request seen at T gives b_ack at T+2.
  - Back-to-back throughput is one access per 3 cycles.
- Handshake rules:
  - B holds b_req, b_we, b_addr and b_wdata stable until b_ack.
  - B must drop b_req in the cycle after b_ack, otherwise that cycle is a new request.
  - APB inputs are sampled only in IDLE. The memory side never sees the APB setup phase.
- The loser of arbitration keeps its request. It is served in the next IDLE, so its worst-case latency is 5 cycles. No starvation in ARB_MODE=0.
- If psel drops before pready (protocol violation), the access still completes to memory and pready is still pulsed.
- Reset mid-operation:
  - Returns to IDLE with all outputs cleared the next cycle.
  - A write already sampled by the memory stands.
  - No ack or pready is issued for the interrupted access.
- Never more than one memory access in flight. mem_rden and mem_wren are never both 1.

Test Plan:
- APB write paddr=0x10, pwdata=0xA5, then APB read 0x10 -> write gives mem_ce=mem_wren=1 for one cycle and pready at T+2; read returns prdata=0xA5 with pready at T+2 and pslverr=0.
- B write b_addr=0x20, b_wdata=0x3C, then B read 0x20 -> b_ack is a single-cycle pulse at T+2; b_rdata=0x3C; b_err=0.
- ARB_MODE=0, A and B request in the same cycle, three times in a row -> grants go A, B, A (first tie after reset goes to A); each requester's data is correct.
- ARB_MODE=1, A and B both continuously requesting -> A is always granted first on a tie; B is served in the IDLE after each A completion.
- DEPTH=128, APB read at 0x90 and B write at 0xFF -> pslverr=1 with prdata=0; b_err=1; mem_ce never asserted; memory contents unchanged.
- rst_n=0 asserted during ACCESS of a B read -> the next cycle is IDLE, b_ack is never pulsed, and all memory controls are 0.
